// File: rtl/fpn_threshold_calc_pkg.sv
// Shared definitions for the FPN threshold stage: result-word field slices,
// buffer depth, FSM state encoding and a small saturation helper.
package fpn_threshold_calc_pkg;

  localparam int POS_MSB  = 47;
  localparam int POS_LSB  = 24;
  localparam int MEAN_MSB = 23;
  localparam int MEAN_LSB = 16;
  localparam int MOM_MSB  = 15;
  localparam int MOM_LSB  = 0;

  localparam int FPN_N_ENTRIES = 24;
  localparam int SQRT_ITERS    = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DIV_M = 3'd3,
    ST_DIV_S = 3'd4,
    ST_SQRT  = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  function automatic logic [7:0] sat_u8(input logic [9:0] v);
    return (v > 10'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/fpn_seq_div.sv
// Restoring divider: one load cycle, then W shift/subtract steps; quotient is floor.
// o_done is high during the final step; the quotient is valid from the next cycle.
module fpn_seq_div #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_quotient
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     r_rem;
  logic [W-1:0]     r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [W:0]       w_shift;
  logic [W:0]       w_diff;

  assign w_shift = {r_rem, r_quo[W-1]};
  assign w_diff  = w_shift - {1'b0, i_divisor};

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_en) begin
      if (i_clr) begin
        r_busy <= 1'b0;
      end else if (i_start) begin
        r_rem  <= '0;
        r_quo  <= i_dividend;
        r_cnt  <= CNT_W'(W);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (!w_diff[W]) begin
          r_rem <= w_diff[W-1:0];
          r_quo <= {r_quo[W-2:0], 1'b1};
        end else begin
          r_rem <= w_shift[W-1:0];
          r_quo <= {r_quo[W-2:0], 1'b0};
        end
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_busy && (r_cnt == CNT_W'(1));
  assign o_quotient = r_quo;

endmodule

// File: rtl/fpn_threshold_calc.sv
// Drains the FPN result buffer once per frame and derives background mean,
// variance and detection threshold. Define FPN_HOTPIX_EN to exclude the max-mean entry.
module fpn_threshold_calc
  import fpn_threshold_calc_pkg::*;
#(
  parameter int N_ENTRIES = FPN_N_ENTRIES,
  parameter int K_SIGMA   = 3,
  parameter int SUM_W     = 21
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        vs_in,
  input  logic        res_valid,
  output logic        res_rd_en,
  input  logic [47:0] res_data,
  output logic        thr_valid,
  output logic [7:0]  bg_mean,
  output logic [15:0] bg_var,
  output logic [7:0]  threshold,
  output logic        thr_sat,
  output logic [23:0] hot_pos
);

  localparam int CNT_W = ($clog2(N_ENTRIES) > 4) ? $clog2(N_ENTRIES) : 4;
`ifdef FPN_HOTPIX_EN
  localparam int DIVISOR = N_ENTRIES - 1;
`else
  localparam int DIVISOR = N_ENTRIES;
`endif

  state_e           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_vs_d, r_armed, r_rd_d;
  logic [SUM_W-1:0] r_sum_m, r_sum_s, w_sum_m_nxt, w_sum_s_nxt, w_quo;
  logic [7:0]       r_m, r_root, w_mean, w_trial, w_root_nxt;
  logic [15:0]      r_v, w_mom, w_s, w_mm, w_sq, w_v;
  logic [23:0]      w_pos;
  logic [2:0]       w_bit;
  logic [9:0]       w_t;
  logic             w_vs_rise, w_abort, w_load_out;
  logic             w_div_start, w_div_busy, w_div_done;
  logic             r_thr_valid, r_thr_sat;
  logic [7:0]       r_bg_mean, r_threshold;
  logic [15:0]      r_bg_var;

  assign w_pos  = res_data[POS_MSB:POS_LSB];
  assign w_mean = res_data[MEAN_MSB:MEAN_LSB];
  assign w_mom  = res_data[MOM_MSB:MOM_LSB];

  assign w_vs_rise  = vs_in && !r_vs_d;
  assign w_abort    = w_vs_rise && (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_load_out = enable && (r_state == ST_SQRT) && (w_next == ST_DONE);

  // One square-root bit per SQRT cycle, MSB first, starting at r_cnt == 1.
  assign w_bit      = 3'(CNT_W'(SQRT_ITERS) - r_cnt);
  assign w_trial    = r_root | (8'd1 << w_bit);
  assign w_sq       = 16'(w_trial) * 16'(w_trial);
  assign w_root_nxt = (w_sq <= r_v) ? w_trial : r_root;
  assign w_s        = w_quo[15:0];
  assign w_mm       = 16'(r_m) * 16'(r_m);
  assign w_v        = (w_s >= w_mm) ? (w_s - w_mm) : '0;
  assign w_t        = 10'(r_m) + 10'(K_SIGMA) * 10'(w_root_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (enable) begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (res_valid && r_armed) w_next = ST_READ;
      ST_READ:  if (r_cnt == CNT_W'(N_ENTRIES - 1)) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_DIV_M;
      ST_DIV_M: if (w_div_done) w_next = ST_DIV_S;
      ST_DIV_S: if (w_div_done) w_next = ST_SQRT;
      ST_SQRT:  if (r_cnt == CNT_W'(SQRT_ITERS)) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  always_comb begin
    res_rd_en   = enable && (r_state == ST_READ);
    w_div_start = ((r_state == ST_DIV_M) || (r_state == ST_DIV_S)) && !w_div_busy;
  end

  fpn_seq_div #(.W(SUM_W)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (enable),
    .i_clr      (r_state == ST_IDLE),
    .i_start    (w_div_start),
    .i_dividend ((r_state == ST_DIV_M) ? r_sum_m : r_sum_s),
    .i_divisor  (SUM_W'(DIVISOR)),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );

`ifdef FPN_HOTPIX_EN
  logic        r_hot_any, w_new_max;
  logic [7:0]  r_max_mean, w_max_mean;
  logic [15:0] r_max_mom, w_max_mom;
  logic [23:0] r_max_pos, w_max_pos, r_hot_pos;
  logic        w_unused;

  always_comb begin
    w_new_max   = !r_hot_any || (w_mean > r_max_mean);
    w_max_mean  = w_new_max ? w_mean : r_max_mean;
    w_max_mom   = w_new_max ? w_mom  : r_max_mom;
    w_max_pos   = w_new_max ? w_pos  : r_max_pos;
    w_sum_m_nxt = r_sum_m + SUM_W'(w_mean);
    w_sum_s_nxt = r_sum_s + SUM_W'(w_mom);
    if (r_state == ST_DRAIN) begin
      w_sum_m_nxt = w_sum_m_nxt - SUM_W'(w_max_mean);
      w_sum_s_nxt = w_sum_s_nxt - SUM_W'(w_max_mom);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hot_any  <= 1'b0;
      r_max_mean <= '0;
      r_max_mom  <= '0;
      r_max_pos  <= '0;
      r_hot_pos  <= '0;
    end else if (enable) begin
      if (r_state == ST_IDLE) begin
        r_hot_any <= 1'b0;
      end else if (r_rd_d) begin
        r_hot_any  <= 1'b1;
        r_max_mean <= w_max_mean;
        r_max_mom  <= w_max_mom;
        r_max_pos  <= w_max_pos;
      end
      if (w_load_out) r_hot_pos <= r_max_pos;
    end
  end

  assign hot_pos  = r_hot_pos;
  assign w_unused = ^w_quo[SUM_W-1:16];
`else
  logic w_unused;

  assign w_sum_m_nxt = r_sum_m + SUM_W'(w_mean);
  assign w_sum_s_nxt = r_sum_s + SUM_W'(w_mom);
  assign hot_pos     = '0;
  assign w_unused    = ^{w_pos, w_quo[SUM_W-1:16]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d      <= 1'b0;
      r_armed     <= 1'b1;
      r_rd_d      <= 1'b0;
      r_sum_m     <= '0;
      r_sum_s     <= '0;
      r_m         <= '0;
      r_v         <= '0;
      r_root      <= '0;
      r_thr_valid <= 1'b0;
      r_thr_sat   <= 1'b0;
      r_bg_mean   <= '0;
      r_bg_var    <= '0;
      r_threshold <= '0;
    end else if (enable) begin
      r_vs_d <= vs_in;
      r_rd_d <= res_rd_en;
      // A held-high res_valid must be seen low once before the next frame is read.
      if (r_state == ST_DONE)          r_armed <= 1'b0;
      else if (w_abort || !res_valid)  r_armed <= 1'b1;
      if (r_state == ST_IDLE) begin
        r_sum_m <= '0;
        r_sum_s <= '0;
      end else if (r_rd_d) begin
        r_sum_m <= w_sum_m_nxt;
        r_sum_s <= w_sum_s_nxt;
      end
      if (w_div_start && (r_state == ST_DIV_S)) r_m <= w_quo[7:0];
      if (r_state == ST_SQRT) begin
        if (r_cnt == '0) begin
          r_v    <= w_v;
          r_root <= '0;
        end else begin
          r_root <= w_root_nxt;
        end
      end
      r_thr_valid <= w_load_out;
      if (w_load_out) begin
        r_bg_mean   <= r_m;
        r_bg_var    <= r_v;
        r_threshold <= sat_u8(w_t);
        r_thr_sat   <= (w_t > 10'd255);
      end
    end
  end

  assign thr_valid = r_thr_valid;
  assign bg_mean   = r_bg_mean;
  assign bg_var    = r_bg_var;
  assign threshold = r_threshold;
  assign thr_sat   = r_thr_sat;

endmodule

// File: tb/tb_fpn_threshold_calc.sv
// Directed bench for fpn_threshold_calc: an upstream buffer model with 1-cycle read
// latency feeds hand-computed frames; results, latency, abort and re-arm are checked.
module tb_fpn_threshold_calc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        vs_in = 1'b0;
  logic        res_valid = 1'b0;
  logic        res_rd_en;
  logic [47:0] res_data;
  logic        thr_valid;
  logic [7:0]  bg_mean;
  logic [15:0] bg_var;
  logic [7:0]  threshold;
  logic        thr_sat;
  logic [23:0] hot_pos;

  logic [47:0] mem [24];
  int          rd_ptr = 0;
  int          errors = 0;
  int          checks = 0;

`ifdef FPN_HOTPIX_EN
  localparam bit HOTPIX = 1'b1;
`else
  localparam bit HOTPIX = 1'b0;
`endif
  localparam logic [23:0] HOT0 = HOTPIX ? 24'h100000 : 24'h0;
  localparam logic [23:0] HOT1 = HOTPIX ? 24'h100001 : 24'h0;

  fpn_threshold_calc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .vs_in     (vs_in),
    .res_valid (res_valid),
    .res_rd_en (res_rd_en),
    .res_data  (res_data),
    .thr_valid (thr_valid),
    .bg_mean   (bg_mean),
    .bg_var    (bg_var),
    .threshold (threshold),
    .thr_sat   (thr_sat),
    .hot_pos   (hot_pos)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (res_rd_en) begin
      res_data <= mem[rd_ptr];
      rd_ptr = (rd_ptr + 1) % 24;
    end
  end

  task automatic load(input logic [7:0] ma, input logic [15:0] sa,
                      input logic [7:0] mb, input logic [15:0] sb);
    for (int i = 0; i < 24; i++)
      mem[i] = {24'h100000 + 24'(i), (i % 2 == 0) ? ma : mb, (i % 2 == 0) ? sa : sb};
    rd_ptr = 0;
  endtask

  task automatic run_frame(input string name, input logic [7:0] em, input logic [15:0] ev,
                           input logic [7:0] et, input logic es, input logic [23:0] eh,
                           input bit hold);
    int first_rd, thr_cyc, nrd;
    first_rd = -1; thr_cyc = -1; nrd = 0;
    @(negedge clk);
    res_valid = 1'b1;
    for (int c = 0; c < 400 && thr_cyc < 0; c++) begin
      @(negedge clk);
      if (res_rd_en) begin
        if (first_rd < 0) first_rd = c;
        nrd++;
      end
      if (thr_valid) thr_cyc = c;
    end
    checks++;
    if (thr_cyc < 0) begin
      errors++; $display("FAIL %s thr_valid timeout after 400 cycles", name);
    end
    checks++;
    if (thr_cyc - first_rd != 78) begin
      errors++; $display("FAIL %s latency got %0d exp 78", name, thr_cyc - first_rd);
    end
    checks++;
    if (nrd != 24) begin
      errors++; $display("FAIL %s rd_en cycles got %0d exp 24", name, nrd);
    end
    checks++;
    if (bg_mean !== em) begin
      errors++; $display("FAIL %s bg_mean got %0d exp %0d", name, bg_mean, em);
    end
    checks++;
    if (bg_var !== ev) begin
      errors++; $display("FAIL %s bg_var got %0d exp %0d", name, bg_var, ev);
    end
    checks++;
    if (threshold !== et) begin
      errors++; $display("FAIL %s threshold got %0d exp %0d", name, threshold, et);
    end
    checks++;
    if (thr_sat !== es) begin
      errors++; $display("FAIL %s thr_sat got %0b exp %0b", name, thr_sat, es);
    end
    checks++;
    if (hot_pos !== eh) begin
      errors++; $display("FAIL %s hot_pos got %h exp %h", name, hot_pos, eh);
    end
    @(negedge clk);
    checks++;
    if (thr_valid !== 1'b0) begin
      errors++; $display("FAIL %s thr_valid pulse wider than 1 cycle", name);
    end
    if (!hold) res_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({res_rd_en, thr_valid, bg_mean, bg_var, threshold, thr_sat, hot_pos} !== '0) begin
      errors++;
      $display("FAIL reset outputs got rd=%0b v=%0b m=%0d var=%0d t=%0d s=%0b h=%h exp all 0",
               res_rd_en, thr_valid, bg_mean, bg_var, threshold, thr_sat, hot_pos);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_uniform;
    load(8'd100, 16'd10100, 8'd100, 16'd10100);
    run_frame("uniform", 8'd100, 16'd100, 8'd130, 1'b0, HOT0, 1'b0);
  endtask

  task automatic test_alternating;
    load(8'd90, 16'd8200, 8'd110, 16'd12200);
    run_frame("alternating", HOTPIX ? 8'd99 : 8'd100, HOTPIX ? 16'd312 : 16'd200,
              HOTPIX ? 8'd150 : 8'd142, 1'b0, HOT1, 1'b0);
  endtask

  task automatic test_var_clamp;
    load(8'd200, 16'd30000, 8'd200, 16'd30000);
    run_frame("var_clamp", 8'd200, 16'd0, 8'd200, 1'b0, HOT0, 1'b0);
  endtask

  task automatic test_saturation;
    load(8'd250, 16'd65535, 8'd250, 16'd65535);
    run_frame("saturation", 8'd250, 16'd3035, 8'd255, 1'b1, HOT0, 1'b0);
  endtask

  task automatic test_abort;
    int nrd, nrd_after, nthr;
    nrd = 0; nrd_after = 0; nthr = 0;
    load(8'd100, 16'd10100, 8'd100, 16'd10100);
    @(negedge clk);
    res_valid = 1'b1;
    for (int c = 0; c < 100 && nrd < 10; c++) begin
      @(negedge clk);
      if (res_rd_en) nrd++;
    end
    checks++;
    if (nrd != 10) begin
      errors++; $display("FAIL abort reach got %0d reads exp 10", nrd);
    end
    vs_in = 1'b1;
    res_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (res_rd_en !== 1'b0) begin
      errors++; $display("FAIL abort rd_en got %0b exp 0", res_rd_en);
    end
    repeat (150) begin
      @(negedge clk);
      if (res_rd_en) nrd_after++;
      if (thr_valid) nthr++;
    end
    checks++;
    if (nthr != 0 || nrd_after != 0) begin
      errors++; $display("FAIL abort quiet got thr=%0d rd=%0d exp 0 0", nthr, nrd_after);
    end
    checks++;
    if ({bg_mean, bg_var, threshold, thr_sat, hot_pos} !== {8'd250, 16'd3035, 8'd255, 1'b1, HOT0}) begin
      errors++;
      $display("FAIL abort held outputs got m=%0d v=%0d t=%0d s=%0b h=%h exp 250 3035 255 1 %h",
               bg_mean, bg_var, threshold, thr_sat, hot_pos, HOT0);
    end
    vs_in = 1'b0;
  endtask

  task automatic test_rearm;
    int nrd;
    nrd = 0;
    load(8'd100, 16'd10100, 8'd100, 16'd10100);
    run_frame("rearm_first", 8'd100, 16'd100, 8'd130, 1'b0, HOT0, 1'b1);
    repeat (150) begin
      @(negedge clk);
      if (res_rd_en) nrd++;
    end
    checks++;
    if (nrd != 0) begin
      errors++; $display("FAIL rearm held valid got %0d reads exp 0", nrd);
    end
    res_valid = 1'b0;
    @(negedge clk);
    load(8'd90, 16'd8200, 8'd110, 16'd12200);
    run_frame("rearm_second", HOTPIX ? 8'd99 : 8'd100, HOTPIX ? 16'd312 : 16'd200,
              HOTPIX ? 8'd150 : 8'd142, 1'b0, HOT1, 1'b0);
  endtask

`ifdef FPN_HOTPIX_EN
  task automatic test_hotpix;
    load(8'd100, 16'd10100, 8'd100, 16'd10100);
    mem[7] = {24'h05A0C3, 8'd250, 16'd10100};
    run_frame("hotpix", 8'd100, 16'd100, 8'd130, 1'b0, 24'h05A0C3, 1'b0);
  endtask
`endif

  task automatic test_reset_midop;
    int nrd;
    nrd = 0;
    load(8'd100, 16'd10100, 8'd100, 16'd10100);
    @(negedge clk);
    res_valid = 1'b1;
    for (int c = 0; c < 100 && nrd < 5; c++) begin
      @(negedge clk);
      if (res_rd_en) nrd++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({res_rd_en, thr_valid, bg_mean, bg_var, threshold, thr_sat, hot_pos} !== '0) begin
      errors++;
      $display("FAIL reset_midop outputs got rd=%0b v=%0b m=%0d var=%0d t=%0d s=%0b h=%h exp all 0",
               res_rd_en, thr_valid, bg_mean, bg_var, threshold, thr_sat, hot_pos);
    end
    res_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset;
    test_uniform;
    test_alternating;
    test_var_clamp;
    test_saturation;
    test_abort;
    test_rearm;
`ifdef FPN_HOTPIX_EN
    test_hotpix;
`endif
    test_reset_midop;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
